// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_pkg;

   localparam logic [3:0] BLANK_CODE = 4'd11;
   localparam int         N_DIGITS   = 8;

   typedef struct packed {
      logic       blank;
      logic [3:0] code;
   } digit_entry_t;

   localparam digit_entry_t DARK_ENTRY = '{blank: 1'b1, code: 4'd0};

   typedef enum logic {
      IDLE,
      PENDING
   } commit_state_t;

endpackage

// File: rtl/seg_scan_ctrl_timer.sv
// Slot timer: divides the clock into digit slots and eight slots into a frame.
module seg_slot_timer
   import seg_pkg::*;
#(
   parameter  int SCAN_DIV = 1000,
   localparam int CNT_W    = $clog2(SCAN_DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] cnt,
   output logic [2:0]       slot,
   output logic             boundary,
   output logic             frame_start
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);

   assign boundary = (cnt == LAST_CNT) && (slot == 3'(N_DIGITS - 1));

   // Advance the in-slot counter, step the slot on wrap, and flag the cycle after a frame wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         slot        <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= boundary;
         if (cnt == LAST_CNT) begin
            cnt  <= '0;
            slot <= slot + 3'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller: double-buffered digit bank, frame-aligned commit, and
// dead-time/brightness windowed active-low digit enables feeding the _7seg decoder.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DEAD_CYC = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [2:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic       wr_blank,
   input  logic       commit_req,
   output logic       commit_pending,
   input  logic [2:0] bright,
   output logic [7:0] en,
   output logic [3:0] num,
   output logic       frame_start
);

   localparam int          CNT_W  = $clog2(SCAN_DIV);
   localparam logic [31:0] DEAD_W = 32'(DEAD_CYC);
   localparam logic [31:0] SPAN_W = 32'(SCAN_DIV - DEAD_CYC);

   logic [CNT_W-1:0] cnt;
   logic [2:0]       slot;
   logic             boundary;

   digit_entry_t  shadow_bank [N_DIGITS];
   digit_entry_t  active_bank [N_DIGITS];
   commit_state_t state_q;
   commit_state_t state_d;
   logic          load_active;
   logic          wr_accept;
   logic [2:0]    bright_q;

   logic [31:0]   win_len;
   logic [31:0]   cnt_ext;
   logic          in_window;
   digit_entry_t  cur_entry;
   logic [7:0]    en_d;
   logic [3:0]    num_d;

   seg_slot_timer #(
      .SCAN_DIV (SCAN_DIV)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .cnt         (cnt),
      .slot        (slot),
      .boundary    (boundary),
      .frame_start (frame_start)
   );

   // Writes are held off while a commit waits, so the snapshot taken at the boundary is stable.
   assign wr_ready       = (state_q == IDLE);
   assign commit_pending = (state_q == PENDING);
   assign wr_accept      = wr_valid && wr_ready;

   // Commit state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A request arms the commit; the armed commit fires on the next frame boundary only.
   always_comb begin
      state_d     = state_q;
      load_active = 1'b0;
      case (state_q)
         IDLE: begin
            if (commit_req) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (boundary) begin
               load_active = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Shadow bank takes accepted writes; later writes to the same digit overwrite earlier ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            shadow_bank[i] <= DARK_ENTRY;
         end
      end else if (wr_accept) begin
         shadow_bank[wr_addr] <= '{blank: wr_blank, code: wr_data};
      end
   end

   // Active bank is replaced as a whole at a frame boundary so no frame is ever mixed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            active_bank[i] <= DARK_ENTRY;
         end
      end else if (load_active) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            active_bank[i] <= shadow_bank[i];
         end
      end
   end

   // Brightness only changes between frames to keep every digit in a frame equally lit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bright_q <= '0;
      end else if (boundary) begin
         bright_q <= bright;
      end
   end

   assign win_len   = ((32'(bright_q) + 32'd1) * SPAN_W) >> 3;
   assign cnt_ext   = 32'(cnt);
   assign in_window = (cnt_ext >= DEAD_W) && (cnt_ext < (DEAD_W + win_len));
   assign cur_entry = active_bank[slot];

   // Decide which single digit (if any) is lit in this cycle and what it shows.
   always_comb begin
      en_d  = 8'hFF;
      num_d = BLANK_CODE;
      if (!cur_entry.blank && in_window) begin
         en_d[slot] = 1'b0;
         num_d      = cur_entry.code;
      end
   end

   // Register the drive so the pins change cleanly one cycle after the slot position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en  <= 8'hFF;
         num <= BLANK_CODE;
      end else begin
         en  <= en_d;
         num <= num_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with SCAN_DIV=16, DEAD_CYC=2.
module tb_seg_scan_ctrl;

   localparam int SD    = 16;
   localparam int DC    = 2;
   localparam int FRAME = SD * 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [2:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
   logic       wr_blank = 1'b0;
   logic       commit_req = 1'b0;
   logic       commit_pending;
   logic [2:0] bright = '0;
   logic [7:0] en;
   logic [3:0] num;
   logic       frame_start;

   int errors = 0;
   int checks = 0;

   logic [7:0] en_log  [1:FRAME];
   logic [3:0] num_log [1:FRAME];

   seg_scan_ctrl #(
      .SCAN_DIV (SD),
      .DEAD_CYC (DC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_blank       (wr_blank),
      .commit_req     (commit_req),
      .commit_pending (commit_pending),
      .bright         (bright),
      .en             (en),
      .num            (num),
      .frame_start    (frame_start)
   );

   always #5 clk = ~clk;

   // Reference model: time since reset gives slot and position; banks are plain arrays.
   int         m_t = 0;
   int         m_bright = 0;
   logic       m_pending = 1'b0;
   logic [3:0] m_code_sh  [8];
   logic       m_blank_sh [8];
   logic [3:0] m_code_act [8];
   logic       m_blank_act[8];
   logic [7:0] exp_en = 8'hFF;
   logic [3:0] exp_num = 4'd11;
   logic       exp_fs = 1'b0;

   function automatic logic isBoundary(int t);
      return (t % FRAME) == FRAME - 1;
   endfunction

   function automatic logic litAt(int t, int br, logic blank);
      int c;
      int w;
      c = t % SD;
      w = ((br + 1) * (SD - DC)) >> 3;
      return !blank && (c >= DC) && (c < DC + w);
   endfunction

   function automatic logic [7:0] expEn(int t, int br, logic blank);
      logic [7:0] one;
      one = 8'b1;
      if (litAt(t, br, blank)) return ~(one << ((t / SD) % 8));
      return 8'hFF;
   endfunction

   function automatic logic [3:0] expNum(int t, int br, logic blank, logic [3:0] code);
      if (litAt(t, br, blank)) return code;
      return 4'd11;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t       <= 0;
         m_bright  <= 0;
         m_pending <= 1'b0;
         exp_en    <= 8'hFF;
         exp_num   <= 4'd11;
         exp_fs    <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            m_code_sh[i]   <= 4'd0;
            m_blank_sh[i]  <= 1'b1;
            m_code_act[i]  <= 4'd0;
            m_blank_act[i] <= 1'b1;
         end
      end else begin
         exp_en  <= expEn(m_t, m_bright, m_blank_act[(m_t / SD) % 8]);
         exp_num <= expNum(m_t, m_bright, m_blank_act[(m_t / SD) % 8], m_code_act[(m_t / SD) % 8]);
         exp_fs  <= isBoundary(m_t);
         if (isBoundary(m_t)) m_bright <= int'(bright);
         if (m_pending) begin
            if (isBoundary(m_t)) begin
               m_code_act  <= m_code_sh;
               m_blank_act <= m_blank_sh;
               m_pending   <= 1'b0;
            end
         end else if (commit_req) begin
            m_pending <= 1'b1;
         end
         if (wr_valid && !m_pending) begin
            m_code_sh[wr_addr]  <= wr_data;
            m_blank_sh[wr_addr] <= wr_blank;
         end
         m_t <= m_t + 1;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Every cycle the DUT must agree with the model.
   always @(negedge clk) begin
      checkOutput("en", int'(en), int'(exp_en));
      checkOutput("num", int'(num), int'(exp_num));
      checkOutput("frame_start", int'(frame_start), int'(exp_fs));
      checkOutput("commit_pending", int'(commit_pending), int'(m_pending));
      checkOutput("wr_ready", int'(wr_ready), int'(!m_pending));
   end

   task automatic waitFrameStart(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_start && n < 400);
      if (!frame_start) checkOutput("frame_start_timeout", 0, 1);
   endtask

   task automatic scanFrame(input int changeAt, input int newBright);
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clk);
         en_log[k]  = en;
         num_log[k] = num;
         if (k == changeAt) bright = 3'(newBright);
      end
   endtask

   function automatic int lowCount(int s);
      int n;
      n = 0;
      for (int k = 16 * s + 1; k <= 16 * s + 16; k++) begin
         if (en_log[k] != 8'hFF) n++;
      end
      return n;
   endfunction

   task automatic writeDigit(input int addr, input int data, input logic blank, output int waited);
      wr_valid = 1'b1;
      wr_addr  = 3'(addr);
      wr_data  = 4'(data);
      wr_blank = blank;
      waited   = 0;
      while (!wr_ready && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      if (!wr_ready) checkOutput("wr_ready_timeout", 0, 1);
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic pulseCommit();
      commit_req = 1'b1;
      @(negedge clk);
      commit_req = 1'b0;
   endtask

   task automatic applyStimulus();
      wr_valid   = 1'($urandom % 2);
      wr_addr    = 3'($urandom % 8);
      wr_data    = 4'($urandom % 16);
      wr_blank   = 1'($urandom % 4 == 0);
      commit_req = 1'($urandom % 40 == 0);
      if ($urandom % 300 == 0) bright = 3'($urandom % 8);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int waited;

      // Reset and idle frames.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_en", int'(en), 8'hFF);
      checkOutput("reset_num", int'(num), 11);
      checkOutput("reset_wr_ready", int'(wr_ready), 1);
      rst_n = 1'b1;
      waitFrameStart(n);
      checkOutput("first_frame_period", n, 128);
      waitFrameStart(n);
      checkOutput("second_frame_period", n, 128);
      checkOutput("idle_en", int'(en), 8'hFF);

      // Full brightness scan of digits 0..7.
      bright = 3'd7;
      for (int d = 0; d < 8; d++) writeDigit(d, d, 1'b0, waited);
      pulseCommit();
      checkOutput("pending_after_req", int'(commit_pending), 1);
      waitFrameStart(n);
      checkOutput("pending_cleared", int'(commit_pending), 0);
      scanFrame(0, 0);
      checkOutput("full_k2_dead", int'(en_log[2]), 8'hFF);
      checkOutput("full_k3_en", int'(en_log[3]), 8'hFE);
      checkOutput("full_k3_num", int'(num_log[3]), 0);
      checkOutput("full_k16_en", int'(en_log[16]), 8'hFE);
      checkOutput("full_k17_en", int'(en_log[17]), 8'hFF);
      checkOutput("full_k19_en", int'(en_log[19]), 8'hFD);
      checkOutput("full_k115_en", int'(en_log[115]), 8'h7F);
      checkOutput("full_k115_num", int'(num_log[115]), 7);
      checkOutput("full_low_slot4", lowCount(4), 14);

      // Dimming applied mid-frame only takes effect next frame.
      scanFrame(40, 0);
      checkOutput("dim_same_frame", lowCount(5), 14);
      scanFrame(40, 3);
      checkOutput("dim0_slot0", lowCount(0), 1);
      checkOutput("dim0_slot7", lowCount(7), 1);
      scanFrame(0, 0);
      checkOutput("dim3_slot1", lowCount(1), 7);
      checkOutput("dim3_slot6", lowCount(6), 7);

      // Writes stall while a commit waits for the boundary.
      pulseCommit();
      checkOutput("ready_low_pending", int'(wr_ready), 0);
      writeDigit(2, 9, 1'b0, waited);
      checkOutput("write_wait_cycles", waited, 127);
      waitFrameStart(n);
      scanFrame(0, 0);
      checkOutput("digit2_old_en", int'(en_log[35]), 8'hFB);
      checkOutput("digit2_old_num", int'(num_log[35]), 2);

      // Write and commit in the same cycle.
      wr_valid   = 1'b1;
      wr_addr    = 3'd5;
      wr_data    = 4'hA;
      wr_blank   = 1'b0;
      commit_req = 1'b1;
      @(negedge clk);
      wr_valid   = 1'b0;
      commit_req = 1'b0;
      waitFrameStart(n);
      scanFrame(0, 0);
      checkOutput("digit5_en", int'(en_log[83]), 8'hDF);
      checkOutput("digit5_num", int'(num_log[83]), 10);
      checkOutput("digit2_new_num", int'(num_log[35]), 9);

      // Commit requested on the boundary cycle lands one frame later.
      writeDigit(0, 12, 1'b0, waited);
      repeat (126) @(negedge clk);
      commit_req = 1'b1;
      @(negedge clk);
      commit_req = 1'b0;
      checkOutput("boundary_fs", int'(frame_start), 1);
      checkOutput("boundary_pending", int'(commit_pending), 1);
      scanFrame(0, 0);
      checkOutput("boundary_old_num", int'(num_log[3]), 0);
      checkOutput("boundary_applied", int'(commit_pending), 0);
      scanFrame(0, 0);
      checkOutput("boundary_new_num", int'(num_log[3]), 12);

      // Blanked digit stays dark.
      writeDigit(3, 0, 1'b1, waited);
      pulseCommit();
      waitFrameStart(n);
      scanFrame(0, 0);
      checkOutput("blank_low_slot3", lowCount(3), 0);
      checkOutput("blank_num_slot3", int'(num_log[51]), 11);
      checkOutput("blank_low_slot2", lowCount(2), 7);

      // Asynchronous reset mid-slot with a commit armed.
      pulseCommit();
      repeat (20) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("async_en", int'(en), 8'hFF);
      checkOutput("async_num", int'(num), 11);
      checkOutput("async_pending", int'(commit_pending), 0);
      checkOutput("async_ready", int'(wr_ready), 1);
      checkOutput("async_fs", int'(frame_start), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised traffic against the model, with one reset in the middle.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            #3 rst_n = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end
         applyStimulus();
      end
      wr_valid   = 1'b0;
      commit_req = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
